// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard over the shared open-drain lines.
// The PS/2 clock and data pins carry an 11-bit frame: start 0, D0..D7,
// odd parity, and stop 1. The device generates the clock. The host changes
// DATA after each falling edge it sees. After the stop bit the device pulls
// DATA low for one more clock as the acknowledge.
//
// Ports:
//   clk_i          board clock
//   rst_n_i        asynchronous active-low reset; releases both lines at once
//   tx_data_i      byte to send, sampled on accept
//   tx_valid_i     request to send tx_data_i
//   tx_ready_o     high only while idle and ready to accept
//   busy_o         high while a transfer is in progress
//                  (tells the receive path to ignore the lines)
//   tx_done_o      one-cycle pulse at the end of a transfer
//   tx_err_o       valid with tx_done_o: 1 = no ACK or timeout
//   ps2_clk_in_i   raw PS2_CLK pin level (asynchronous)
//   ps2_data_in_i  raw PS2_DATA pin level (asynchronous)
//   ps2_clk_oe_o   1 = pull PS2_CLK low, 0 = release
//   ps2_data_oe_o  1 = pull PS2_DATA low, 0 = release
//
// Handshake: a byte is accepted on a rising clk_i edge where
// tx_valid_i & tx_ready_o. tx_valid_i is ignored while tx_ready_o is low.
// tx_ready_o rises the cycle after tx_done_o, so a new request can be
// accepted then.
//
// INHIBIT_CYCLES and START_HOLD_CYCLES must both be at least 1.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES    = 5000,
    parameter int unsigned START_HOLD_CYCLES = 50,
    parameter int unsigned TIMEOUT_CYCLES    = 750000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       busy_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    input  logic       ps2_clk_in_i,
    input  logic       ps2_data_in_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int unsigned HOLD_MAX = (INHIBIT_CYCLES > START_HOLD_CYCLES) ?
                                       INHIBIT_CYCLES : START_HOLD_CYCLES;
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(START_HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e           state_q;
    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_prev_q;
    logic [9:0]       shift_q;
    logic [3:0]       bit_cnt_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             ack_err_q;
    logic             tx_ready_q;
    logic             busy_q;
    logic             tx_done_q;
    logic             tx_err_q;
    logic             clk_oe_q;
    logic             data_oe_q;

    logic       clk_s;
    logic       data_s;
    logic       clk_fall;
    logic [9:0] frame_d;
    logic       active;
    logic       to_hit;
    logic       finish;
    logic       finish_err;

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_s;

    // The stop bit is kept in bit 9 only to make the frame complete.
    // The stop bit is sent by releasing DATA, not by shifting it out.
    assign frame_d = {1'b1, ~^tx_data_i, tx_data_i};

    // The timeout counter runs from the moment CLK is released
    // until the transfer ends.
    assign active = (state_q == S_SHIFT) || (state_q == S_ACK) ||
                    (state_q == S_WAIT_IDLE);
    assign to_hit = active && (to_cnt_q == TO_LAST);

    // The timeout wins over any edge or bus-idle condition
    // that arrives in the same cycle.
    assign finish     = to_hit || ((state_q == S_WAIT_IDLE) && clk_s && data_s);
    assign finish_err = to_hit || ack_err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            // Idle bus level is high.
            // Presetting the synchronizers avoids a false falling edge after reset.
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            to_cnt_q    <= '0;
            ack_err_q   <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in_i};
            data_sync_q <= {data_sync_q[0], ps2_data_in_i};
            clk_prev_q  <= clk_s;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;

            if (finish) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                tx_done_q <= 1'b1;
                tx_err_q  <= finish_err;
                busy_q    <= 1'b0;
                state_q   <= S_IDLE;
            end else begin
                if (active) begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
                case (state_q)
                    S_IDLE: begin
                        // The cycle that carries tx_done_o
                        // re-arms tx_ready_o for the next cycle.
                        if (!tx_ready_q) begin
                            tx_ready_q <= 1'b1;
                        end else if (tx_valid_i) begin
                            shift_q    <= frame_d;
                            bit_cnt_q  <= '0;
                            hold_cnt_q <= '0;
                            to_cnt_q   <= '0;
                            ack_err_q  <= 1'b0;
                            tx_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            clk_oe_q   <= 1'b1;
                            state_q    <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (hold_cnt_q == INH_LAST) begin
                            hold_cnt_q <= '0;
                            data_oe_q  <= 1'b1;   // start bit
                            state_q    <= S_REQ;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                        end
                    end
                    S_REQ: begin
                        if (hold_cnt_q == REQ_LAST) begin
                            hold_cnt_q <= '0;
                            to_cnt_q   <= '0;
                            clk_oe_q   <= 1'b0;
                            state_q    <= S_SHIFT;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                        end
                    end
                    S_SHIFT: begin
                        if (clk_fall) begin
                            if (bit_cnt_q == 4'd9) begin
                                data_oe_q <= 1'b0;   // stop bit: release the line
                                state_q   <= S_ACK;
                            end else begin
                                // The line is open-drain,
                                // so a '1' bit is sent by releasing it.
                                data_oe_q <= ~shift_q[0];
                                shift_q   <= shift_q >> 1;
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    S_ACK: begin
                        if (clk_fall) begin
                            ack_err_q <= data_s;
                            state_q   <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        // The exit condition is handled by 'finish' above.
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready_o    = tx_ready_q;
    assign busy_o        = busy_q;
    assign tx_done_o     = tx_done_q;
    assign tx_err_o      = tx_err_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx.
// The hold and timeout parameters are scaled down to keep the run short.
// A PS/2 device model produces the clock and records the bits it samples
// on each rising edge. The expected frame is built from the byte using
// plain arithmetic: start 0, data LSB first, odd parity, stop 1.
module tb_ps2_host_tx;

    localparam int INH = 1000;
    localparam int SH  = 50;
    localparam int TO  = 4000;
    localparam int H   = 20;     // device half clock period, in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err, clk_oe, data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
    assign ps2_data_line = ~(data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_HOLD_CYCLES(SH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .tx_data_i(tx_data),
        .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready),
        .busy_o(busy),
        .tx_done_o(tx_done),
        .tx_err_o(tx_err),
        .ps2_clk_in_i(ps2_clk_line),
        .ps2_data_in_i(ps2_data_line),
        .ps2_clk_oe_o(clk_oe),
        .ps2_data_oe_o(data_oe)
    );

    int vectors = 0;
    int miscompares = 0;

    logic got_q[$];
    logic exp_q[$];

    int   oe_cnt, rel_cyc, done_cyc;
    logic done_seen, err_seen, oe_at_done, doe_at_done, ready_next, done_next;

    // Reference model: the expected 11-bit line sequence for a byte.
    task automatic build_exp(input logic [7:0] b);
        int ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i]);
            ones += int'(b[i]);
        end
        exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        exp_q.push_back(1'b1);
    endtask

    // Driver: wait for ready, then present one byte for the accept edge.
    task automatic drive_accept(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready got=%b exp=1", tx_ready);
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device model.
    // It waits for the host to release CLK while holding DATA low.
    // It samples the start bit, then produces n_edges clock pulses.
    // It samples DATA on each rising edge and can give the ACK.
    task automatic device(input int n_edges, input bit ack);
        int n = 0;
        got_q.delete();
        while (!(clk_oe === 1'b0 && data_oe === 1'b1) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) return;
        got_q.push_back(ps2_data_line);
        repeat (H) @(negedge clk);
        for (int i = 1; i <= n_edges; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i <= 10) got_q.push_back(ps2_data_line);
            if (i == 10 && ack) dev_data_low = 1'b1;
            if (i == 11) dev_data_low = 1'b0;
            if (i < n_edges) repeat (H) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    // Monitor.
    // It counts the cycles where CLK_OE is high and notes when CLK is released.
    // It captures the outputs at the TX_DONE pulse and one cycle later.
    task automatic monitor(input int budget);
        oe_cnt = 0; rel_cyc = -1; done_cyc = -1;
        done_seen = 0; err_seen = 0; oe_at_done = 1'bx; doe_at_done = 1'bx;
        for (int c = 0; c < budget; c++) begin
            if (clk_oe === 1'b1) oe_cnt++;
            else if (oe_cnt > 0 && rel_cyc < 0) rel_cyc = c;
            if (tx_done === 1'b1) begin
                done_seen = 1'b1; done_cyc = c; err_seen = tx_err;
                oe_at_done = clk_oe; doe_at_done = data_oe;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        ready_next = tx_ready;
        done_next  = tx_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%b exp=1", tx_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
        vectors++; if (tx_done !== 1'b0 || tx_err !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%b%b exp=00", tx_done, tx_err); end
        vectors++; if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin miscompares++; $display("FAIL rst_oe got=%b%b exp=00", clk_oe, data_oe); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL post_rst got rdy=%b busy=%b exp rdy=1 busy=0", tx_ready, busy); end
    endtask

    // One complete transfer, with the device either giving the ACK or not.
    task automatic test_frame(input logic [7:0] b, input bit ack);
        drive_accept(b);
        build_exp(b);
        fork
            device(11, ack);
            monitor(INH + SH + 2000);
        join
        vectors++; if (got_q.size() != 11) begin miscompares++; $display("FAIL frame_len byte=%02h got=%0d exp=11", b, got_q.size()); end
        for (int i = 0; i < 11; i++) begin
            if (i < got_q.size()) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL frame_bit byte=%02h bit%0d got=%b exp=%b", b, i, got_q[i], exp_q[i]); end
            end
        end
        vectors++; if (oe_cnt != INH + SH) begin miscompares++; $display("FAIL clk_oe_len byte=%02h got=%0d exp=%0d", b, oe_cnt, INH + SH); end
        vectors++; if (done_seen !== 1'b1) begin miscompares++; $display("FAIL done_seen byte=%02h got=%b exp=1", b, done_seen); end
        vectors++; if (err_seen !== !ack) begin miscompares++; $display("FAIL tx_err byte=%02h got=%b exp=%b", b, err_seen, !ack); end
        vectors++; if (oe_at_done !== 1'b0 || doe_at_done !== 1'b0) begin miscompares++; $display("FAIL oe_at_done got=%b%b exp=00", oe_at_done, doe_at_done); end
        vectors++; if (ready_next !== 1'b1 || done_next !== 1'b0) begin miscompares++; $display("FAIL after_done got rdy=%b done=%b exp rdy=1 done=0", ready_next, done_next); end
    endtask

    task automatic test_parity();
        test_frame(8'h00, 1'b1);
        test_frame(8'hFF, 1'b1);
        test_frame(8'h01, 1'b1);
    endtask

    task automatic test_nack();
        test_frame(8'(($urandom_range(0, 255))), 1'b0);
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        drive_accept(b);
        build_exp(b);
        fork
            device(4, 1'b1);
            monitor(INH + SH + TO + 500);
        join
        vectors++; if (done_seen !== 1'b1) begin miscompares++; $display("FAIL to_done got=%b exp=1", done_seen); end
        vectors++; if (err_seen !== 1'b1) begin miscompares++; $display("FAIL to_err got=%b exp=1", err_seen); end
        vectors++; if (done_cyc - rel_cyc != TO) begin miscompares++; $display("FAIL to_latency got=%0d exp=%0d", done_cyc - rel_cyc, TO); end
        vectors++; if (oe_at_done !== 1'b0 || doe_at_done !== 1'b0) begin miscompares++; $display("FAIL to_oe got=%b%b exp=00", oe_at_done, doe_at_done); end
        vectors++; if (ready_next !== 1'b1) begin miscompares++; $display("FAIL to_ready got=%b exp=1", ready_next); end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL to_bit%0d got_len=%0d exp=%b", i, got_q.size(), exp_q[i]); end
        end
    endtask

    // Reset while the host drives bit D4, which follows falling edge 5.
    task automatic test_reset_mid();
        logic [7:0] b;
        logic       e;
        int         n = 0;
        int         seen = 0;
        b = 8'h0F;
        e = ~b[4];
        drive_accept(b);
        while (!(clk_oe === 1'b0 && data_oe === 1'b1) && n < 20000) begin @(negedge clk); n++; end
        repeat (H) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            dev_clk_low = 1'b1; repeat (H) @(negedge clk);
            dev_clk_low = 1'b0; repeat (H) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        vectors++; if (data_oe !== e || clk_oe !== 1'b0) begin miscompares++; $display("FAIL mid_pre got clk_oe=%b data_oe=%b exp clk_oe=0 data_oe=%b", clk_oe, data_oe, e); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin miscompares++; $display("FAIL mid_rst_oe got=%b%b exp=00", clk_oe, data_oe); end
        vectors++; if (tx_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_flags got rdy=%b busy=%b done=%b exp 1/0/0", tx_ready, busy, tx_done); end
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (tx_done === 1'b1) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL mid_no_done got=%0d exp=0", seen); end
        vectors++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_idle got rdy=%b busy=%b exp 1/0", tx_ready, busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [2];
        bytes[0] = 8'hED;
        bytes[1] = 8'h02;
        @(negedge clk);
        tx_data = bytes[0];
        tx_valid = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            build_exp(bytes[f]);
            fork
                device(11, 1'b1);
                monitor(INH + SH + 2000);
                begin
                    // Scramble tx_data while the frame is in flight.
                    repeat (100) begin @(negedge clk); tx_data = 8'($urandom_range(0, 255)); end
                    if (f == 0) tx_data = bytes[1];
                end
            join
            vectors++; if (got_q.size() != 11) begin miscompares++; $display("FAIL b2b_len f%0d got=%0d exp=11", f, got_q.size()); end
            for (int i = 0; i < 11; i++) begin
                if (i < got_q.size()) begin
                    vectors++;
                    if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_bit f%0d bit%0d got=%b exp=%b", f, i, got_q[i], exp_q[i]); end
                end
            end
            vectors++; if (done_seen !== 1'b1 || err_seen !== 1'b0) begin miscompares++; $display("FAIL b2b_done f%0d got done=%b err=%b exp 1/0", f, done_seen, err_seen); end
            vectors++; if (ready_next !== 1'b1) begin miscompares++; $display("FAIL b2b_ready f%0d got=%b exp=1", f, ready_next); end
            if (f == 0) begin
                @(negedge clk);
                vectors++; if (tx_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got rdy=%b busy=%b exp 0/1", tx_ready, busy); end
                tx_valid = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            test_frame(8'($urandom_range(0, 255)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hED, 1'b1);
        test_parity();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared PS2_CLK/PS2_DATA open-drain lines.
- It is the opposite direction of the keyboard receive path and sits beside it on the same pins.
- BUSY tells the receive path to ignore line activity while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 5000, CLK cycles PS2_CLK is held low before the request (100 us at 50 MHz).
- START_HOLD_CYCLES, 50, CLK cycles DATA and CLK are both held low before CLK is released.
- TIMEOUT_CYCLES, 750000, maximum CLK cycles from CLK release to ACK completion (15 ms at 50 MHz).

Ports:
- CLK  in  1  board clock.
- RST_N  in  1  asynchronous, active-low reset.
- TX_DATA  in  8  byte to send; sampled on accept.
- TX_VALID  in  1  request to send TX_DATA.
- TX_READY  out  1  high only in IDLE; a transfer is accepted when TX_VALID & TX_READY.
- BUSY  out  1  high in every state except IDLE.
- TX_DONE  out  1  one-cycle pulse when the transfer ends (success or failure).
- TX_ERR  out  1  valid only with TX_DONE: 1 = no ACK or timeout.
- PS2_CLK_IN  in  1  raw PS2_CLK pin level (asynchronous).
- PS2_DATA_IN  in  1  raw PS2_DATA pin level (asynchronous).
- PS2_CLK_OE  out  1  1 = drive PS2_CLK low, 0 = release (pull-up).
- PS2_DATA_OE  out  1  1 = drive PS2_DATA low, 0 = release.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State goes to IDLE; all counters clear.
  - Outputs: TX_READY=1, BUSY=0, TX_DONE=0, TX_ERR=0, PS2_CLK_OE=0, PS2_DATA_OE=0. Lines are released immediately, including mid-frame.
- Input sync: both pin inputs pass through 2-flop synchronizers. A falling edge is prev=1 and now=0 on the synchronized PS2_CLK.
- Frame register (latched on accept): {1'b1 stop, odd parity = ~^TX_DATA, TX_DATA[7:0]}. Shifted LSB first.
- IDLE:
  - TX_READY=1.
  - On accept: latch the frame, clear counters, go to INHIBIT next cycle.
- INHIBIT: CLK_OE=1, DATA_OE=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ:
  - CLK_OE=1, DATA_OE=1 (start bit 0) for START_HOLD_CYCLES cycles.
  - Then CLK_OE=0; go to SHIFT and start the timeout counter.
- SHIFT:
  - DATA_OE keeps the start-bit value until the first falling edge.
  - On falling edges 1..9: DATA_OE <= ~(D0..D7, parity) in order. Update occurs the cycle after the edge is detected.
  - On falling edge 10: DATA_OE <= 0 (stop bit = released line). Go to ACK.
- ACK:
  - On the next falling edge, sample synchronized DATA. Low = ACK ok; high = ERR flag set.
  - Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized CLK=1 and DATA=1. Then pulse TX_DONE for 1 cycle, with TX_ERR = ERR flag, and return to IDLE.
- Timeout:
  - The counter runs in SHIFT, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: CLK_OE=0, DATA_OE=0, TX_DONE=1, TX_ERR=1, go to IDLE. Timeout has priority over any edge arriving in the same cycle.
- In IDLE, TX_VALID is ignored while TX_READY=0. TX_DATA changes after accept do not affect the frame.
- Back-to-back: TX_READY rises the cycle after TX_DONE. A new accept in that cycle is legal.
- PS2_CLK_OE is never 1 outside INHIBIT/REQ. PS2_DATA_OE is never 1 in IDLE, ACK or WAIT_IDLE.
- Device clock edges seen during INHIBIT/REQ are ignored.

Test Plan:
- TX_DATA=0xED, device model clocks 11 bits and ACKs low -> bits sampled on device rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1; TX_DONE pulse with TX_ERR=0; CLK_OE held exactly 5000+50 cycles.
- Parity cases: 0x00 -> parity 1; 0xFF -> parity 1; 0x01 -> parity 0; each completes with TX_ERR=0.
- Device never pulls DATA low on the 11th edge -> TX_DONE=1 with TX_ERR=1; lines released; TX_READY=1 next cycle.
- Device stops clocking after 4 edges -> at CLK release + 750000 cycles, TX_DONE=1, TX_ERR=1, CLK_OE=0, DATA_OE=0, state IDLE.
- RST_N asserted during SHIFT bit 5 -> CLK_OE=0, DATA_OE=0 with no clock edge; TX_READY=1, BUSY=0, and no TX_DONE.
- Two bytes 0xED then 0x02, with TX_VALID held high -> second accept occurs the cycle after the first TX_DONE; both complete with TX_ERR=0; TX_DATA toggled mid-frame has no effect.
